// File: rtl/hs_bus_amba_axis_rr_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_PORTS AXI-Stream sources onto
// one sink. A grant is held from the first beat through the tlast beat, so
// packets from different sources never interleave on the sink.
module hs_bus_amba_axis_rr_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TSTRB_WIDTH = TDATA_WIDTH/8,
  parameter int TKEEP_WIDTH = TDATA_WIDTH/8,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  // source side, packed per port
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*TSTRB_WIDTH-1:0] s_axis_tstrb,
  input  logic [NUM_PORTS*TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*TID_WIDTH-1:0]   s_axis_tid,
  input  logic [NUM_PORTS*TDEST_WIDTH-1:0] s_axis_tdest,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]             s_axis_twakeup,
  // sink side
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [TSTRB_WIDTH-1:0]           m_axis_tstrb,
  output logic [TKEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [TID_WIDTH-1:0]             m_axis_tid,
  output logic [TDEST_WIDTH-1:0]           m_axis_tdest,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                             m_axis_twakeup,
  // grant status
  output logic                             grant_valid,
  output logic [IDX_W-1:0]                 grant_idx
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_grant_valid;

  logic             w_req_any;
  logic [IDX_W-1:0] w_winner;
  logic             w_last_hs;

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... with wrap at NUM_PORTS.
  // Iterating from the far end down lets the nearest requester win last.
  // Only depends on registered state and tvalid, never feeds tready directly.
  always_comb begin
    int w_scan_idx;
    w_req_any  = 1'b0;
    w_winner   = '0;
    w_scan_idx = 0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= NUM_PORTS) w_scan_idx = w_scan_idx - NUM_PORTS;
      if (s_axis_tvalid[w_scan_idx]) begin
        w_req_any = 1'b1;
        w_winner  = IDX_W'(w_scan_idx);
      end
    end
  end

  // Sink mux and tready steering; everything is quiet while idle.
  // Constant-index slices keep unused index codes (non power-of-two
  // NUM_PORTS) from ever selecting anything.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    m_axis_tdest  = '0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    if (r_state == ST_BUSY) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_grant_idx == IDX_W'(i)) begin
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tdata     = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
          m_axis_tstrb     = s_axis_tstrb[i*TSTRB_WIDTH +: TSTRB_WIDTH];
          m_axis_tkeep     = s_axis_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH];
          m_axis_tlast     = s_axis_tlast[i];
          m_axis_tid       = s_axis_tid[i*TID_WIDTH +: TID_WIDTH];
          m_axis_tdest     = s_axis_tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
          m_axis_tuser     = s_axis_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  // Wakeup bypasses the grant so a sleeping sink can be woken by anyone.
  assign m_axis_twakeup = |s_axis_twakeup;

  assign w_last_hs   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;

  // Grant FSM: IDLE picks a winner, BUSY holds it until the tlast handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_grant_idx   <= w_winner;
            r_grant_valid <= 1'b1;
            r_state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_last_hs) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= (r_grant_idx == IDX_W'(NUM_PORTS-1)) ?
                             '0 : r_grant_idx + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_bus_amba_axis_rr_arbiter.sv
// Directed bench for the packet round-robin arbiter: a 4-port instance for
// most scenarios plus a 3-port instance for the non power-of-two wrap.
module tb_hs_bus_amba_axis_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // 4-port instance
  logic [3:0]  s_tvalid, s_tready, s_tlast, s_twakeup;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb, s_tkeep, s_tid, s_tdest, s_tuser;
  logic        m_tvalid, m_tready, m_tlast, m_twakeup;
  logic [7:0]  m_tdata;
  logic        m_tstrb, m_tkeep, m_tid, m_tdest, m_tuser;
  logic        gvld;
  logic [1:0]  gidx;

  hs_bus_amba_axis_rr_arbiter #(.NUM_PORTS(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tstrb(s_tstrb), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .s_axis_twakeup(s_twakeup),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tstrb(m_tstrb), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .m_axis_twakeup(m_twakeup),
    .grant_valid(gvld), .grant_idx(gidx)
  );

  // 3-port instance
  logic [2:0]  s3_tvalid, s3_tready, s3_tlast, s3_twakeup;
  logic [23:0] s3_tdata;
  logic [2:0]  s3_tstrb, s3_tkeep, s3_tid, s3_tdest, s3_tuser;
  logic        m3_tvalid, m3_tlast, m3_twakeup;
  logic        m3_tready;
  logic [7:0]  m3_tdata;
  logic        m3_tstrb, m3_tkeep, m3_tid, m3_tdest, m3_tuser;
  logic        g3vld;
  logic [1:0]  g3idx;

  hs_bus_amba_axis_rr_arbiter #(.NUM_PORTS(3)) dut3 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s3_tvalid), .s_axis_tready(s3_tready), .s_axis_tdata(s3_tdata),
    .s_axis_tstrb(s3_tstrb), .s_axis_tkeep(s3_tkeep), .s_axis_tlast(s3_tlast),
    .s_axis_tid(s3_tid), .s_axis_tdest(s3_tdest), .s_axis_tuser(s3_tuser),
    .s_axis_twakeup(s3_twakeup),
    .m_axis_tvalid(m3_tvalid), .m_axis_tready(m3_tready), .m_axis_tdata(m3_tdata),
    .m_axis_tstrb(m3_tstrb), .m_axis_tkeep(m3_tkeep), .m_axis_tlast(m3_tlast),
    .m_axis_tid(m3_tid), .m_axis_tdest(m3_tdest), .m_axis_tuser(m3_tuser),
    .m_axis_twakeup(m3_twakeup),
    .grant_valid(g3vld), .grant_idx(g3idx)
  );

  int n_chk = 0;
  int n_err = 0;

  // source model: packets left, length, position in packet, running seq
  int   left[4], len[4], pos[4], seq[4];
  bit   drop[4];
  bit   tgl_rdy;
  bit   prev_stall;
  logic [7:0] prev_data;
  logic [7:0] got_q[$];
  int   gnt_q[$];
  logic [7:0] q3[$];
  int   steps;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i]       = (left[i] > 0) && !drop[i];
      s_tdata[i*8 +: 8] = 8'(i*16 + seq[i]);
      s_tlast[i]        = (pos[i] == len[i]-1);
      s_tstrb[i]        = 1'b1;
      s_tkeep[i]        = 1'b1;
      s_tid[i]          = i[0];
      s_tdest[i]        = i[1];
      s_tuser[i]        = 1'b0;
    end
  endtask

  // one clock: observe before the edge, advance the source model after it
  task automatic step();
    logic [3:0] hs;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (prev_stall && m_tvalid) chk("stable_tdata", 32'(m_tdata), 32'(prev_data));
    prev_stall = m_tvalid & ~m_tready;
    prev_data  = m_tdata;
    if (m_tvalid && m_tready) begin
      got_q.push_back(m_tdata);
      if (m_tlast) gnt_q.push_back(int'(gidx));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        seq[i]++;
        if (pos[i] == len[i]-1) begin pos[i] = 0; left[i]--; end
        else pos[i]++;
      end
    end
    if (tgl_rdy) m_tready = ~m_tready;
    drive_srcs();
    steps++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      left[i] = 0; len[i] = 1; pos[i] = 0; seq[i] = 0; drop[i] = 0;
    end
    m_tready = 1'b1; tgl_rdy = 0; s_twakeup = '0;
    drive_srcs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete(); gnt_q.delete();
    prev_stall = 0; steps = 0;
  endtask

  task automatic run_until(input int nbeats, input int budget, input string tag);
    while (got_q.size() < nbeats && steps < budget) step();
    if (got_q.size() < nbeats) chk({tag, "_timeout"}, 32'(got_q.size()), 32'(nbeats));
  endtask

  initial begin
    logic [7:0] exp2[15];
    logic [7:0] exp4[6];
    logic [7:0] exp6[5];
    int         gexp2[5];
    s3_tvalid = '0; s3_tlast = '1; s3_tdata = 24'h020100; s3_twakeup = '0;
    s3_tstrb = '1; s3_tkeep = '1; s3_tid = '0; s3_tdest = '0; s3_tuser = '0;
    m3_tready = 1'b1;
    do_reset();

    // 1: idle after reset, nothing requested
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_gvld", 32'(gvld), 0);
      chk("rst_mvalid", 32'(m_tvalid), 0);
      chk("rst_sready", 32'(s_tready), 0);
    end
    s_twakeup = 4'b0100;
    @(negedge clk) chk("wakeup_or", 32'(m_twakeup), 1);
    s_twakeup = 4'b0000;
    @(negedge clk) chk("wakeup_none", 32'(m_twakeup), 0);

    // 2: all four sources, 3-beat packets, src0 sends two
    do_reset();
    left = '{2, 1, 1, 1}; len = '{3, 3, 3, 3};
    drive_srcs();
    exp2 = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22,
             8'h30, 8'h31, 8'h32, 8'h03, 8'h04, 8'h05};
    gexp2 = '{0, 1, 2, 3, 0};
    run_until(15, 100, "rr4");
    chk("rr4_cycles", 32'(steps), 20);
    for (int i = 0; i < 15 && i < got_q.size(); i++) chk("rr4_beat", 32'(got_q[i]), 32'(exp2[i]));
    chk("rr4_ngrants", 32'(gnt_q.size()), 5);
    for (int i = 0; i < 5 && i < gnt_q.size(); i++) chk("rr4_order", 32'(gnt_q[i]), 32'(gexp2[i]));

    // 3: source 2 alone, sink ready toggling every cycle
    do_reset();
    left[2] = 1; len[2] = 4; tgl_rdy = 1;
    drive_srcs();
    repeat (12) step();
    tgl_rdy = 0; m_tready = 1'b1;
    chk("bp_nbeats", 32'(got_q.size()), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("bp_beat", 32'(got_q[i]), 32'(8'h20 + i));

    // 4: src1 stalls mid-packet, src0 waiting; grant must not move
    do_reset();
    left[1] = 1; len[1] = 4;
    drive_srcs();
    step(); step();
    drop[1] = 1; left[0] = 1; len[0] = 2;
    drive_srcs();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_gidx", 32'(gidx), 1);
      chk("hold_gvld", 32'(gvld), 1);
    end
    drop[1] = 0;
    drive_srcs();
    run_until(6, 60, "hold");
    exp4 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h01};
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk("hold_beat", 32'(got_q[i]), 32'(exp4[i]));
    chk("hold_ngrants", 32'(gnt_q.size()), 2);
    if (gnt_q.size() >= 2) begin
      chk("hold_g0", 32'(gnt_q[0]), 1);
      chk("hold_g1", 32'(gnt_q[1]), 0);
    end

    // lone requester with 1-beat packets is re-granted every 2 cycles
    do_reset();
    left[0] = 3; len[0] = 1;
    drive_srcs();
    run_until(3, 30, "lone");
    chk("lone_cycles", 32'(steps), 6);

    // 5: reset on the 2nd beat, with rr_ptr moved away from 0 beforehand
    do_reset();
    left[1] = 1; len[1] = 1;
    drive_srcs();
    step(); step();
    left[2] = 1; len[2] = 4;
    drive_srcs();
    step(); step();
    chk("pre_rst_gidx", 32'(gidx), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_gvld", 32'(gvld), 0);
    chk("mid_rst_gidx", 32'(gidx), 0);
    chk("mid_rst_mvalid", 32'(m_tvalid), 0);
    chk("mid_rst_sready", 32'(s_tready), 0);
    rst = 1'b0;
    left = '{1, 0, 1, 1}; len = '{1, 1, 1, 1}; pos = '{0, 0, 0, 0};
    drive_srcs();
    @(posedge clk);
    #1;
    chk("post_rst_gvld", 32'(gvld), 1);
    chk("post_rst_rrptr0", 32'(gidx), 0);

    // 6: three ports, all valid, single-beat packets
    do_reset();
    s3_tvalid = 3'b111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m3_tvalid && m3_tready) q3.push_back(m3_tdata);
      @(posedge clk);
    end
    s3_tvalid = '0;
    exp6 = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01};
    chk("np3_nbeats", 32'(q3.size()), 5);
    for (int i = 0; i < 5 && i < q3.size(); i++) chk("np3_order", 32'(q3[i]), 32'(exp6[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
